// File: rtl/layer_mixer_if.sv
// Bus between the layer sources / control plane and the layer mixer.
// Clock and reset stay outside the interface as plain ports.
interface layer_mixer_if #(
  parameter int LAYERS = 3,
  parameter int BPC    = 6,
  parameter int AW     = 4
);
  localparam int PW  = 3 * BPC;
  localparam int CAW = (LAYERS > 2) ? $clog2(LAYERS) : 1;

  // cfgWrite and fadeCmdValid are single-cycle strobes with no ready: the mixer
  // samples them on every clock and never back-pressures, so a strobe high for
  // one cycle is exactly one transfer.
  logic [2:0]           pixelClockPhase;
  logic                 fieldStart;
  logic [LAYERS*PW-1:0] rgb_in;
  logic [LAYERS-1:0]    layerEnable;
  logic                 cfgWrite;
  logic [CAW-1:0]       cfgAddr;
  logic [PW-1:0]        cfgKey;
  logic                 fadeCmdValid;
  logic [1:0]           fadeCmd;
  logic [PW-1:0]        rgb_out;
  logic [AW:0]          fadeAlpha;
  logic                 fadeBusy;
  logic [1:0]           fadeState;

  modport master (
    output pixelClockPhase, fieldStart, rgb_in, layerEnable,
           cfgWrite, cfgAddr, cfgKey, fadeCmdValid, fadeCmd,
    input  rgb_out, fadeAlpha, fadeBusy, fadeState
  );

  modport slave (
    input  pixelClockPhase, fieldStart, rgb_in, layerEnable,
           cfgWrite, cfgAddr, cfgKey, fadeCmdValid, fadeCmd,
    output rgb_out, fadeAlpha, fadeBusy, fadeState
  );
endinterface

// File: rtl/layer_mixer.sv
// Multi-layer keyed pixel mixer: picks the highest-priority visible layer over
// the background and alpha-blends it using a field-stepped fade controller.
module layer_mixer #(
  parameter int LAYERS = 3,
  parameter int BPC    = 6,
  parameter int AW     = 4
) (
  input logic           pixelClockX6,
  input logic           nReset,
  layer_mixer_if.slave  bus
);
  localparam int PW  = 3 * BPC;
  localparam int CAW = (LAYERS > 2) ? $clog2(LAYERS) : 1;
  localparam logic [AW:0] ONE       = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ALPHA_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OPAQUE      = 2'd0,
    FADING_OUT  = 2'd1,
    TRANSPARENT = 2'd2,
    FADING_IN   = 2'd3
  } fade_state_t;

  fade_state_t state, state_next;
  logic [AW:0] alpha, alpha_next, inv_alpha;
  logic        cmd_taken;
  logic        tick;

  logic [PW-1:0] key [1:LAYERS-1];
  logic          win_hit;
  logic [PW-1:0] win_pix;
  logic          fg_hit;
  logic [PW-1:0] fg_pix, bg_pix, rgb_q, blend_pix;
  logic [BPC+AW:0] mix [3];

  assign tick = (bus.pixelClockPhase == 3'd0);

  // Keys are written on the clock edge, so a tick in the write cycle still
  // compares against the old key.
  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      for (int i = 1; i < LAYERS; i++) key[i] <= '0;
    end else if (bus.cfgWrite) begin
      for (int i = 1; i < LAYERS; i++)
        if (bus.cfgAddr == CAW'(i)) key[i] <= bus.cfgKey;
    end
  end

  // Ascending scan: the last match, i.e. the highest index, wins.
  always_comb begin
    win_hit = 1'b0;
    win_pix = '0;
    for (int i = 1; i < LAYERS; i++) begin
      if (bus.layerEnable[i] && (bus.rgb_in[i*PW +: PW] != key[i])) begin
        win_hit = 1'b1;
        win_pix = bus.rgb_in[i*PW +: PW];
      end
    end
  end

  assign inv_alpha = ONE - alpha;

  always_comb begin
    blend_pix = '0;
    for (int c = 0; c < 3; c++) begin
      mix[c] = ({{(AW+1){1'b0}}, fg_pix[c*BPC +: BPC]} * {{BPC{1'b0}}, alpha})
             + ({{(AW+1){1'b0}}, bg_pix[c*BPC +: BPC]} * {{BPC{1'b0}}, inv_alpha});
      blend_pix[c*BPC +: BPC] = mix[c][AW +: BPC];
    end
  end

  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      fg_hit <= 1'b0;
      fg_pix <= '0;
      bg_pix <= '0;
      rgb_q  <= '0;
    end else if (tick) begin
      fg_hit <= win_hit;
      fg_pix <= win_pix;
      bg_pix <= bus.rgb_in[PW-1:0];
      rgb_q  <= fg_hit ? blend_pix : bg_pix;
    end
  end

  always_ff @(posedge pixelClockX6 or negedge nReset) begin
    if (!nReset) begin
      state <= OPAQUE;
      alpha <= ONE;
    end else begin
      state <= state_next;
      alpha <= alpha_next;
    end
  end

  // An accepted command wins over a same-cycle field step; the step clamps so
  // a reversal parked at an endpoint still lands in the right terminal state.
  always_comb begin
    state_next = state;
    alpha_next = alpha;
    cmd_taken  = 1'b0;
    if (bus.fadeCmdValid) begin
      case (bus.fadeCmd)
        2'b10: if (state == OPAQUE || state == FADING_IN) begin
          state_next = FADING_OUT;
          cmd_taken  = 1'b1;
        end
        2'b01: if (state == TRANSPARENT || state == FADING_OUT) begin
          state_next = FADING_IN;
          cmd_taken  = 1'b1;
        end
        2'b11: begin
          state_next = OPAQUE;
          alpha_next = ONE;
          cmd_taken  = 1'b1;
        end
        default: ;
      endcase
    end
    if (!cmd_taken && bus.fieldStart) begin
      case (state)
        FADING_OUT: begin
          if (alpha <= ALPHA_ONE) begin
            alpha_next = '0;
            state_next = TRANSPARENT;
          end else begin
            alpha_next = alpha - ALPHA_ONE;
          end
        end
        FADING_IN: begin
          if (alpha >= ONE - ALPHA_ONE) begin
            alpha_next = ONE;
            state_next = OPAQUE;
          end else begin
            alpha_next = alpha + ALPHA_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rgb_out   = rgb_q;
  assign bus.fadeAlpha = alpha;
  assign bus.fadeBusy  = (state == FADING_OUT) || (state == FADING_IN);
  assign bus.fadeState = state;

  logic unused_bits;
  assign unused_bits = ^{bus.layerEnable[0],
                         mix[0][AW-1:0], mix[0][BPC+AW],
                         mix[1][AW-1:0], mix[1][BPC+AW],
                         mix[2][AW-1:0], mix[2][BPC+AW]};
endmodule

// File: tb/tb_layer_mixer.sv
// Directed bench for layer_mixer: a reference model derived from the mixing and
// fade rules runs alongside the DUT, plus literal checks on key scenarios.
module tb_layer_mixer;
  localparam int LAYERS = 3;
  localparam int BPC    = 6;
  localparam int AW     = 4;
  localparam int PW     = 3 * BPC;
  localparam int ONE    = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  layer_mixer_if #(.LAYERS(LAYERS), .BPC(BPC), .AW(AW)) bus ();

  layer_mixer #(.LAYERS(LAYERS), .BPC(BPC), .AW(AW)) dut (
    .pixelClockX6 (clk),
    .nReset       (rst_n),
    .bus          (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q holds {hit, fg, bg} for pixels selected but not yet shown.
  logic [2*PW:0] exp_q[$];
  logic [PW-1:0] m_key [LAYERS];
  logic [PW-1:0] exp_rgb;
  int            m_alpha;
  int            m_dir;     // -1 fading out, +1 fading in, 0 settled
  logic [2*PW:0] rec;
  logic          m_hit;
  logic [PW-1:0] m_fg;
  logic          m_taken;

  function automatic logic [PW-1:0] blend(input logic [PW-1:0] fg, input logic [PW-1:0] bg, input int a);
    logic [PW-1:0] r;
    int f, b, v;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      f = int'(fg[c*BPC +: BPC]);
      b = int'(bg[c*BPC +: BPC]);
      v = (f * a + b * (ONE - a)) / ONE;
      r[c*BPC +: BPC] = v[BPC-1:0];
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_alpha = ONE;
      m_dir   = 0;
      for (int i = 0; i < LAYERS; i++) m_key[i] = '0;
      exp_q.delete();
      exp_q.push_back('0);
      exp_rgb = '0;
    end else begin
      if (bus.pixelClockPhase == 3'd0) begin
        rec = exp_q.pop_front();
        exp_rgb = rec[2*PW] ? blend(rec[2*PW-1:PW], rec[PW-1:0], m_alpha) : rec[PW-1:0];
        m_hit = 1'b0;
        m_fg  = '0;
        for (int i = LAYERS - 1; i >= 1; i--) begin
          if (!m_hit && bus.layerEnable[i] && bus.rgb_in[i*PW +: PW] != m_key[i]) begin
            m_hit = 1'b1;
            m_fg  = bus.rgb_in[i*PW +: PW];
          end
        end
        exp_q.push_back({m_hit, m_fg, bus.rgb_in[PW-1:0]});
      end
      if (bus.cfgWrite && bus.cfgAddr != 0 && int'(bus.cfgAddr) < LAYERS)
        m_key[bus.cfgAddr] = bus.cfgKey;
      m_taken = 1'b0;
      if (bus.fadeCmdValid) begin
        if (bus.fadeCmd == 2'b11) begin
          m_alpha = ONE; m_dir = 0; m_taken = 1'b1;
        end else if (bus.fadeCmd == 2'b10 && (m_dir == 1 || (m_dir == 0 && m_alpha == ONE))) begin
          m_dir = -1; m_taken = 1'b1;
        end else if (bus.fadeCmd == 2'b01 && (m_dir == -1 || (m_dir == 0 && m_alpha == 0))) begin
          m_dir = 1; m_taken = 1'b1;
        end
      end
      if (!m_taken && bus.fieldStart && m_dir != 0) begin
        m_alpha = m_alpha + m_dir;
        if (m_alpha <= 0)   begin m_alpha = 0;   m_dir = 0; end
        if (m_alpha >= ONE) begin m_alpha = ONE; m_dir = 0; end
      end
    end
  end

  // Compare process: outputs are registered, so every cycle is meaningful.
  always @(negedge clk) begin
    check("model_rgb_out", 32'(bus.rgb_out), 32'(exp_rgb));
    check("model_alpha", 32'(bus.fadeAlpha), 32'(m_alpha));
    check("model_busy", 32'(bus.fadeBusy), 32'(m_dir != 0));
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(negedge clk);
    bus.pixelClockPhase = (bus.pixelClockPhase == 3'd5) ? 3'd0 : bus.pixelClockPhase + 3'd1;
    bus.fieldStart   = 1'b0;
    bus.fadeCmdValid = 1'b0;
    bus.cfgWrite     = 1'b0;
  endtask

  task automatic align_tick();
    do next_cycle(); while (bus.pixelClockPhase != 3'd0);
  endtask

  // Present a pixel on a tick and check it two ticks later.
  task automatic show(input logic [PW-1:0] l2, input logic [PW-1:0] l1, input logic [PW-1:0] l0,
                      input logic [PW-1:0] want, input string name);
    align_tick();
    bus.rgb_in = {l2, l1, l0};
    repeat (7) next_cycle();
    check(name, 32'(bus.rgb_out), 32'(want));
  endtask

  task automatic cfg(input logic [1:0] addr, input logic [PW-1:0] k);
    next_cycle();
    bus.cfgWrite = 1'b1; bus.cfgAddr = addr; bus.cfgKey = k;
    next_cycle();
  endtask

  task automatic cmd(input logic [1:0] c);
    next_cycle();
    bus.fadeCmdValid = 1'b1; bus.fadeCmd = c;
    next_cycle();
  endtask

  task automatic field();
    next_cycle();
    bus.fieldStart = 1'b1;
    next_cycle();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.pixelClockPhase = 3'd0;
    bus.fieldStart      = 1'b0;
    bus.rgb_in          = '0;
    bus.layerEnable     = 3'b111;
    bus.cfgWrite        = 1'b0;
    bus.cfgAddr         = '0;
    bus.cfgKey          = '0;
    bus.fadeCmdValid    = 1'b0;
    bus.fadeCmd         = 2'b00;

    repeat (3) @(negedge clk);
    check("reset_rgb", 32'(bus.rgb_out), 32'h0);
    check("reset_alpha", 32'(bus.fadeAlpha), 32'd16);
    check("reset_busy", 32'(bus.fadeBusy), 32'd0);
    rst_n = 1'b1;

    // default black key and priority
    show(18'h00000, 18'h3F000, 18'h00FC0, 18'h3F000, "default_key_fg");
    show(18'h00000, 18'h00000, 18'h00FC0, 18'h00FC0, "default_key_black");
    show(18'h0003F, 18'h3F000, 18'h00FC0, 18'h0003F, "prio_layer2");
    bus.layerEnable = 3'b011;
    show(18'h0003F, 18'h3F000, 18'h00FC0, 18'h3F000, "prio_l2_disabled");
    bus.layerEnable = 3'b001;
    show(18'h0003F, 18'h3F000, 18'h00FC0, 18'h00FC0, "prio_all_disabled");
    bus.layerEnable = 3'b111;

    // custom key on layer 1, then writes that must be ignored
    cfg(2'd1, 18'h3FFFF);
    show(18'h00000, 18'h3FFFF, 18'h00FC0, 18'h00FC0, "custom_key_keyed");
    show(18'h00000, 18'h00000, 18'h00FC0, 18'h00000, "black_not_keyed");
    cfg(2'd0, 18'h00000);
    cfg(2'd3, 18'h00000);
    show(18'h00000, 18'h3FFFF, 18'h00FC0, 18'h00FC0, "bad_addr_keyed");
    show(18'h00000, 18'h00000, 18'h00FC0, 18'h00000, "bad_addr_black");
    cfg(2'd1, 18'h00000);

    // fade-out over black background
    bus.rgb_in = {18'h00000, 18'h3F000, 18'h00000};
    cmd(2'b10);
    check("fadeout_busy", 32'(bus.fadeBusy), 32'd1);
    check("fadeout_hold", 32'(bus.fadeAlpha), 32'd16);
    repeat (8) field();
    check("fade8_alpha", 32'(bus.fadeAlpha), 32'd8);
    show(18'h00000, 18'h3F000, 18'h00000, 18'h1F000, "fade8_rgb");
    repeat (8) field();
    check("fade16_alpha", 32'(bus.fadeAlpha), 32'd0);
    check("fade16_busy", 32'(bus.fadeBusy), 32'd0);
    show(18'h00000, 18'h3F000, 18'h00000, 18'h00000, "fade16_rgb");
    field();
    check("fade17_alpha", 32'(bus.fadeAlpha), 32'd0);

    // snap, fade out to 5, reverse colliding with a field step
    cmd(2'b11);
    check("snap_alpha", 32'(bus.fadeAlpha), 32'd16);
    cmd(2'b10);
    repeat (11) field();
    check("rev_at5", 32'(bus.fadeAlpha), 32'd5);
    next_cycle();
    bus.fadeCmdValid = 1'b1; bus.fadeCmd = 2'b01; bus.fieldStart = 1'b1;
    next_cycle();
    check("collide_alpha", 32'(bus.fadeAlpha), 32'd5);
    check("collide_busy", 32'(bus.fadeBusy), 32'd1);
    field();
    check("rev_at6", 32'(bus.fadeAlpha), 32'd6);
    repeat (11) field();
    check("rev_opaque_alpha", 32'(bus.fadeAlpha), 32'd16);
    check("rev_opaque_busy", 32'(bus.fadeBusy), 32'd0);

    // ignored fade-in while opaque: the same-cycle field step is harmless
    next_cycle();
    bus.fadeCmdValid = 1'b1; bus.fadeCmd = 2'b01; bus.fieldStart = 1'b1;
    next_cycle();
    check("ignored_cmd_alpha", 32'(bus.fadeAlpha), 32'd16);
    check("ignored_cmd_busy", 32'(bus.fadeBusy), 32'd0);

    // snap mid-fade
    cmd(2'b10);
    repeat (3) field();
    check("mid_alpha13", 32'(bus.fadeAlpha), 32'd13);
    cmd(2'b11);
    check("snap_mid_alpha", 32'(bus.fadeAlpha), 32'd16);
    check("snap_mid_busy", 32'(bus.fadeBusy), 32'd0);

    // asynchronous reset mid-fade and mid-pixel
    cmd(2'b10);
    repeat (3) field();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rgb", 32'(bus.rgb_out), 32'h0);
    check("async_alpha", 32'(bus.fadeAlpha), 32'd16);
    check("async_busy", 32'(bus.fadeBusy), 32'd0);
    align_tick();
    bus.rgb_in = {18'h00000, 18'h3F000, 18'h00FC0};
    rst_n = 1'b1;
    repeat (6) next_cycle();
    check("post_reset_not_early", 32'(bus.rgb_out), 32'h0);
    next_cycle();
    check("post_reset_first", 32'(bus.rgb_out), 32'h3F000);

    repeat (2) next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: sequence did not complete, got timeout, expected finish");
    $fatal(1);
  end
endmodule

// File: doc/layer_mixer.md
# layer_mixer

Parametrised multi-layer PAL 576i pixel mixer. Takes LAYERS RGB pixel streams on the pixel clock domain and selects the highest-priority non-keyed enabled layer over the background layer, with per-layer programmable key colour. The top-layer result is alpha-blended over the background using a field-stepped fade controller. It sits between the overlay/character generators and the RGB output stage, replacing the single-overlay black-key mixer.

## Interface
Parameters:
- LAYERS, 3: number of input layers. Layer 0 is the background; a higher index has higher priority. Minimum 2.
- BPC, 6: bits per colour channel. Pixel width is PW = 3*BPC, packed {R,G,B}.
- AW, 4: alpha fraction bits. Alpha ranges 0..2^AW inclusive and is held in AW+1 bits.

Ports:
- pixelClockX6  in  1  6x pixel clock; all logic is on its rising edge.
- nReset  in  1  asynchronous, active-low reset.
- pixelClockPhase  in  3  pixel phase counter. A pixel tick is any cycle with phase == 0.
- fieldStart  in  1  one-cycle pulse at each field start.
- rgb_in  in  LAYERS*PW  layer i occupies bits [i*PW +: PW].
- layerEnable  in  LAYERS  per-layer enable. Bit 0 is ignored because the background is always present.
- cfgWrite  in  1  key-register write strobe.
- cfgAddr  in  max(1,$clog2(LAYERS))  layer index for the key write.
- cfgKey  in  PW  key colour to write.
- fadeCmdValid  in  1  fade command strobe.
- fadeCmd  in  2  01 = fade-in, 10 = fade-out, 11 = snap opaque, 00 = no-op.
- rgb_out  out  PW  mixed pixel.
- fadeAlpha  out  AW+1  current alpha.
- fadeBusy  out  1  high while a fade is in progress.

## Operation
- Key registers key[1..LAYERS-1] reset to 0 (black), which preserves the black-key behaviour.
- Key writes:
  - Accepted in any cycle with cfgWrite=1.
  - Ignored when cfgAddr is 0 or >= LAYERS.
  - A write takes effect from the next pixel tick after the write cycle.
- Stage 1 (pixel tick):
  - Scan i = LAYERS-1 down to 1.
  - The first layer with layerEnable[i]=1 and rgb_in[i] != key[i] wins.
  - Register the winner as fgPix with fgHit=1, and register bgPix = rgb_in layer 0.
  - If no layer wins, fgHit=0.
- Stage 2 (next pixel tick):
  - If fgHit=0, rgb_out <= bgPix.
  - If fgHit=1, blend each channel as (fg*a + bg*(2^AW - a)) >> AW, where a = fadeAlpha sampled that cycle.
  - The intermediate width is BPC+AW+1 and the result truncates to BPC. No overflow is possible.
  - a = 2^AW gives fg exactly; a = 0 gives bg exactly.
- Fade FSM states: OPAQUE, FADING_OUT, TRANSPARENT, FADING_IN. Reset state is OPAQUE with alpha = 2^AW.
- Command 10 (fade-out):
  - From OPAQUE or FADING_IN, go to FADING_OUT.
  - Alpha is held where it is, so a reversal continues from the current value.
  - Ignored in other states.
- Command 01 (fade-in):
  - From TRANSPARENT or FADING_OUT, go to FADING_IN.
  - Ignored in other states.
- Command 11 (snap opaque): from any state, alpha = 2^AW and state = OPAQUE.
- Command 00: no effect.
- fieldStart stepping:
  - In FADING_OUT, alpha -= 1. When alpha reaches 0, go to TRANSPARENT.
  - In FADING_IN, alpha += 1. When alpha reaches 2^AW, go to OPAQUE.
  - In OPAQUE and TRANSPARENT, fieldStart has no effect.
- A full fade takes exactly 2^AW fields.
- fadeBusy = (state is FADING_OUT or FADING_IN).

## Timing
- Reset values: rgb_out=0, fadeAlpha=2^AW, fadeBusy=0, pipeline registers=0, fgHit=0.
- Reset is honoured mid-fade and mid-pixel, with immediate asynchronous clear.
- Latency:
  - An input sampled on pixel tick N appears on rgb_out after the clock edge of pixel tick N+1.
  - That is 2 pixel ticks, or 6 clocks.
  - rgb_out holds between ticks.
- Non-tick cycles do not change the pipeline registers.
- Simultaneous fadeCmdValid and fieldStart in the same cycle:
  - An accepted command has priority; no alpha step occurs that cycle.
  - If the command is ignored, the step proceeds normally.
- Fade transitions:
  - Alpha and state update on the clock edge of the command or step.
  - The first pixel blended with the new alpha is the next stage-2 tick.
- Key write and pixel tick in the same cycle: that tick uses the old key.
- layerEnable is sampled only on pixel ticks.

## Test plan
- Reset: assert nReset=0 mid-stream -> rgb_out=0, fadeAlpha=16, fadeBusy=0 immediately. After release, the first valid output appears 2 ticks after the first input.
- Default key (LAYERS=3, BPC=6, AW=4): layer1=0x3F000 enabled, layer0=0x00FC0 -> rgb_out=0x3F000 two ticks later. Then layer1=0x00000 -> rgb_out=0x00FC0.
- Priority:
  - layer2=0x0003F and layer1=0x3F000, both enabled -> 0x0003F.
  - Clear layerEnable[2] -> 0x3F000.
  - Clear layerEnable[1] -> layer0.
- Custom key:
  - Write cfgAddr=1 with key 0x3FFFF; layer1=0x3FFFF -> layer0 is shown.
  - Layer1=0x00000 -> 0x00000 is shown, because black is no longer keyed.
  - A write to cfgAddr=0 or 3 -> no change.
- Fade-out:
  - fadeCmd=10, then fieldStart pulses, with fg=0x3F000 and bg=0x00000.
  - After 8 fields, alpha=8 and rgb_out R=31 (0x1F000).
  - After 16 fields, alpha=0, state TRANSPARENT, fadeBusy=0, rgb_out=0x00000.
  - A 17th fieldStart -> alpha stays 0.
- Reversal and collision:
  - At alpha=5 during fade-out, issue fadeCmd=01 in the same cycle as fieldStart -> alpha stays 5 that cycle.
  - The next field gives alpha=6; 11 more fields give OPAQUE with alpha=16.
  - fadeCmd=11 mid-fade -> alpha=16 and fadeBusy=0 on the next edge.
